// File: rtl/lim_counter_chain.sv
// lim_counter_chain: multi-digit registered counter. Each digit counts modulo
// its own limit, and carries/borrows ripple across the chain within one cycle.
// The chain boundary either wraps or saturates, depending on WRAP.
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   en        count strobe, one step per cycle while high
//   dir       0 = up, 1 = down
//   clear     synchronous clear of every digit (highest priority)
//   load      synchronous parallel load; digits >= limit are clamped to limit-1
//   load_val  packed load value, digit i at [i*W +: W]
//   count     packed registered digit values
//   co        registered one-cycle pulse on a chain-boundary step
//   at_term   combinational; every digit is terminal for the current dir
module lim_counter_chain #(
  parameter int unsigned                N_DIG  = 4,
  parameter int unsigned                W      = 4,
  parameter logic [N_DIG*(W+1)-1:0]     LIMITS = {5'd6, 5'd10, 5'd6, 5'd10},
  parameter bit                         WRAP   = 1'b1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic               dir,
  input  logic               clear,
  input  logic               load,
  input  logic [N_DIG*W-1:0] load_val,
  output logic [N_DIG*W-1:0] count,
  output logic               co,
  output logic               at_term
);

  localparam int unsigned LW = W + 1;
  localparam int unsigned CW = N_DIG * W;

  // HELD: a saturating boundary step has already pulsed co and count is parked there.
  typedef enum logic {ARMED, HELD} sat_state_t;

  sat_state_t       state_q, state_nxt;
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    stepped;
  logic [CW-1:0]    clamped;
  logic             co_nxt;
  logic [W-1:0]     lim_m1 [N_DIG];
  logic [N_DIG-1:0] term;
  logic [N_DIG:0]   chain;

  // Terminal value for counting up, per digit.
  for (genvar g = 0; g < N_DIG; g++) begin : g_lim
    assign lim_m1[g] = W'(LIMITS[g*LW +: LW] - LW'(1));
  end

  // Ripple: digit i steps when every lower digit sits at its terminal value.
  always_comb begin
    chain    = '0;
    term     = '0;
    stepped  = count;
    chain[0] = 1'b1;
    for (int i = 0; i < int'(N_DIG); i++) begin
      term[i]    = dir ? (count[i*W +: W] == '0) : (count[i*W +: W] == lim_m1[i]);
      chain[i+1] = chain[i] & term[i];
      if (chain[i]) begin
        if (term[i]) begin
          stepped[i*W +: W] = dir ? lim_m1[i] : W'(0);
        end else begin
          stepped[i*W +: W] = dir ? (count[i*W +: W] - W'(1))
                                  : (count[i*W +: W] + W'(1));
        end
      end
    end
  end

  assign at_term = chain[N_DIG];

  // Load clamp: an out-of-range digit becomes limit-1.
  always_comb begin
    clamped = load_val;
    for (int i = 0; i < int'(N_DIG); i++) begin
      if ({1'b0, load_val[i*W +: W]} >= LIMITS[i*LW +: LW]) begin
        clamped[i*W +: W] = lim_m1[i];
      end
    end
  end

  // Next state: clear > load > en; saturation re-arms once count moves.
  always_comb begin
    count_nxt = count;
    co_nxt    = 1'b0;
    state_nxt = state_q;
    if (clear) begin
      count_nxt = '0;
      state_nxt = ARMED;
    end else if (load) begin
      count_nxt = clamped;
      state_nxt = ARMED;
    end else if (en) begin
      if (at_term) begin
        if (WRAP) begin
          count_nxt = stepped;
          co_nxt    = 1'b1;
        end else begin
          co_nxt    = (state_q == ARMED);
          state_nxt = HELD;
        end
      end else begin
        count_nxt = stepped;
        state_nxt = ARMED;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      co      <= 1'b0;
      state_q <= ARMED;
    end else begin
      count   <= count_nxt;
      co      <= co_nxt;
      state_q <= state_nxt;
    end
  end

endmodule

// File: tb/tb_lim_counter_chain.sv
// tb_lim_counter_chain: drives a wrapping and a saturating instance with the
// same stimulus and compares both against a value-level model (the count is
// held as a single integer in 0..3599 for the default mm:ss limits).
module tb_lim_counter_chain;

  localparam int M = 3600;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en, dir, clear, load;
  logic [15:0] load_val;
  logic [15:0] count_w, count_s;
  logic        co_w, co_s, at_term_w, at_term_s;

  int   n_chk, n_bad;
  int   mv_w, mv_s;
  logic mco_w, mco_s;
  bit   held_w, held_s;

  always #5 clk = ~clk;

  lim_counter_chain #(.WRAP(1'b1)) dut_w (
    .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .count(count_w), .co(co_w), .at_term(at_term_w)
  );

  lim_counter_chain #(.WRAP(1'b0)) dut_s (
    .clk(clk), .reset_n(reset_n), .en(en), .dir(dir), .clear(clear), .load(load),
    .load_val(load_val), .count(count_s), .co(co_s), .at_term(at_term_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_digits(input int v);
    return {4'(v / 600), 4'((v / 60) % 10), 4'((v / 10) % 6), 4'(v % 10)};
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int lim [4];
    int wt  [4];
    int v;
    int d;
    lim = '{10, 6, 10, 6};
    wt  = '{1, 10, 60, 600};
    v = 0;
    for (int i = 0; i < 4; i++) begin
      d = int'(lv[i*4 +: 4]);
      if (d >= lim[i]) d = lim[i] - 1;
      v += d * wt[i];
    end
    return v;
  endfunction

  function automatic logic exp_term(input int v);
    return dir ? (v == 0) : (v == M - 1);
  endfunction

  task automatic model_apply(input bit wrap, inout int v, inout logic c, inout bit held);
    c = 1'b0;
    if (clear) begin
      v = 0; held = 1'b0;
    end else if (load) begin
      v = from_load(load_val); held = 1'b0;
    end else if (en) begin
      if (exp_term(v)) begin
        if (wrap) begin
          v = dir ? M - 1 : 0;
          c = 1'b1;
        end else begin
          c = !held;
          held = 1'b1;
        end
      end else begin
        v = dir ? v - 1 : v + 1;
        held = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    mv_w = 0; mv_s = 0; mco_w = 1'b0; mco_s = 1'b0; held_w = 1'b0; held_s = 1'b0;
  endtask

  // One clock of stimulus: check at_term before the edge, registered outputs after.
  task automatic drive_step(input logic e, input logic d, input logic c, input logic l,
                            input logic [15:0] lv);
    en = e; dir = d; clear = c; load = l; load_val = lv;
    #1;
    check_eq("at_term_w", 32'(at_term_w), 32'(exp_term(mv_w)));
    check_eq("at_term_s", 32'(at_term_s), 32'(exp_term(mv_s)));
    @(posedge clk);
    model_apply(1'b1, mv_w, mco_w, held_w);
    model_apply(1'b0, mv_s, mco_s, held_s);
    #1;
    check_eq("count_w", 32'(count_w), 32'(to_digits(mv_w)));
    check_eq("co_w",    32'(co_w),    32'(mco_w));
    check_eq("count_s", 32'(count_s), 32'(to_digits(mv_s)));
    check_eq("co_s",    32'(co_s),    32'(mco_s));
  endtask

  initial begin
    logic [15:0] lv;
    logic        d;
    n_chk = 0; n_bad = 0;
    model_reset();
    reset_n = 1'b0; en = 1'b0; dir = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_count", 32'(count_w), 32'h0);
    check_eq("rst_co",    32'(co_w),    32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Count up ten steps from reset.
    repeat (10) drive_step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("up10", 32'(count_w), 32'h0010);

    // Full wrap up, saturation hold on the other instance.
    drive_step(1'b0, 1'b0, 1'b0, 1'b1, 16'h5959);
    drive_step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("wrap_up_cnt", 32'(count_w), 32'h0);
    check_eq("wrap_up_co",  32'(co_w),    32'h1);
    check_eq("sat_cnt1",    32'(count_s), 32'h5959);
    check_eq("sat_co1",     32'(co_s),    32'h1);
    repeat (2) begin
      drive_step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
      check_eq("sat_cnt_hold", 32'(count_s), 32'h5959);
      check_eq("sat_co_hold",  32'(co_s),    32'h0);
    end
    drive_step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    check_eq("sat_down", 32'(count_s), 32'h5958);
    drive_step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("sat_back_co", 32'(co_s), 32'h0);
    drive_step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("sat_rearm_co", 32'(co_s), 32'h1);

    // Full wrap down from zero.
    drive_step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    drive_step(1'b1, 1'b1, 1'b0, 1'b0, 16'h0);
    check_eq("wrap_dn_cnt", 32'(count_w), 32'h5959);
    check_eq("wrap_dn_co",  32'(co_w),    32'h1);
    check_eq("sat_dn_cnt",  32'(count_s), 32'h0);

    // Priority and clamp.
    drive_step(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234);
    check_eq("prio_clear", 32'(count_w), 32'h0);
    check_eq("prio_co",    32'(co_w),    32'h0);
    drive_step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0012);
    check_eq("prio_load", 32'(count_w), 32'h0012);
    drive_step(1'b0, 1'b0, 1'b0, 1'b1, 16'h7F9C);
    check_eq("clamp", 32'(count_w), 32'h5959);

    // Asynchronous reset between edges.
    drive_step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0327);
    check_eq("pre_rst", 32'(count_w), 32'h0327);
    en = 1'b1; dir = 1'b0; load = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_w", 32'(count_w), 32'h0);
    check_eq("async_rst_s", 32'(count_s), 32'h0);
    check_eq("async_rst_co", 32'(co_w), 32'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    drive_step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("resume", 32'(count_w), 32'h0001);

    // Randomized traffic, biased toward the chain boundaries.
    d = 1'b0;
    repeat (1500) begin
      if ($urandom_range(0, 7) == 0) d = ~d;
      case ($urandom_range(0, 5))
        0:       lv = 16'h5959;
        1:       lv = 16'h5958;
        2:       lv = 16'h0000;
        3:       lv = 16'h0001;
        default: lv = 16'($urandom);
      endcase
      drive_step(($urandom_range(0, 7) != 0), d, ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 15) == 0), lv);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
